// File: rtl/hazard_scheduler_if.sv
// Decode-side inputs and interlock/forwarding outputs of the hazard scheduler.
// The scheduler holds the slave side; the decode/EX logic holds the master side.
interface hazard_scheduler_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       D_rs;
  logic [4:0]       D_rt;
  logic             D_use_rs;
  logic             D_use_rt;
  logic [4:0]       D_write_register;
  logic             D_RegWrite;
  logic             D_MemRead;
  logic             D_halt;
  logic             EX_branch_taken;
  logic             HZ_stall_F;
  logic             HZ_stall_D;
  logic             HZ_flush_D;
  logic             HZ_bubble_E;
  logic [1:0]       HZ_fwd_a;
  logic [1:0]       HZ_fwd_b;
  logic [1:0]       HZ_state;
  logic             HZ_halted;
  logic [CNT_W-1:0] HZ_stall_count;
  logic [CNT_W-1:0] HZ_flush_count;

  modport master (
    output D_rs, D_rt, D_use_rs, D_use_rt, D_write_register,
           D_RegWrite, D_MemRead, D_halt, EX_branch_taken,
    input  HZ_stall_F, HZ_stall_D, HZ_flush_D, HZ_bubble_E, HZ_fwd_a,
           HZ_fwd_b, HZ_state, HZ_halted, HZ_stall_count, HZ_flush_count
  );

  modport slave (
    input  D_rs, D_rt, D_use_rs, D_use_rt, D_write_register,
           D_RegWrite, D_MemRead, D_halt, EX_branch_taken,
    output HZ_stall_F, HZ_stall_D, HZ_flush_D, HZ_bubble_E, HZ_fwd_a,
           HZ_fwd_b, HZ_state, HZ_halted, HZ_stall_count, HZ_flush_count
  );
endinterface

// File: rtl/hazard_scheduler.sv
// Interlock controller for the five-stage core: load-use stalls, branch flushes,
// EX forwarding selects and halt draining, from shadow copies of EX/MEM/WB.
module hazard_scheduler #(
  parameter int CNT_W = 16
) (
  input  logic              SYS_clk,
  input  logic              SYS_reset,
  hazard_scheduler_if.slave hz
);

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    DRAIN  = 2'b01,
    HALTED = 2'b10
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  logic       ex_valid, ex_regwrite, ex_memread, ex_use_rs, ex_use_rt;
  logic [4:0] ex_dst, ex_rs, ex_rt;
  logic       mem_valid, mem_regwrite, mem_memread;
  logic [4:0] mem_dst;
  logic       wb_valid, wb_regwrite;
  logic [4:0] wb_dst;

  logic run, hold, load_use, branch, halt_go, bubble;
  logic mem_hit_a, mem_hit_b, wb_hit_a, wb_hit_b;

  function automatic logic slot_hit(input logic valid, input logic regwrite,
                                    input logic [4:0] dst, input logic [4:0] src,
                                    input logic use_src);
    return valid && regwrite && (dst != 5'd0) && use_src && (dst == src);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  assign run  = (state == RUN);
  assign hold = !run;

  assign load_use = run && ex_memread &&
                    (slot_hit(ex_valid, ex_regwrite, ex_dst, hz.D_rs, hz.D_use_rs) ||
                     slot_hit(ex_valid, ex_regwrite, ex_dst, hz.D_rt, hz.D_use_rt));
  // A taken branch wins over both a pending load-use and a halt in decode.
  assign branch  = run && hz.EX_branch_taken;
  assign halt_go = run && hz.D_halt && !load_use && !branch;
  assign bubble  = hold || branch || load_use || halt_go;

  assign mem_hit_a = slot_hit(mem_valid, mem_regwrite, mem_dst, ex_rs, ex_use_rs) && !mem_memread;
  assign mem_hit_b = slot_hit(mem_valid, mem_regwrite, mem_dst, ex_rt, ex_use_rt) && !mem_memread;
  assign wb_hit_a  = slot_hit(wb_valid, wb_regwrite, wb_dst, ex_rs, ex_use_rs);
  assign wb_hit_b  = slot_hit(wb_valid, wb_regwrite, wb_dst, ex_rt, ex_use_rt);

  assign hz.HZ_stall_F     = hold || (load_use && !branch);
  assign hz.HZ_stall_D     = hold || (load_use && !branch);
  assign hz.HZ_flush_D     = branch;
  assign hz.HZ_bubble_E    = bubble;
  assign hz.HZ_fwd_a       = mem_hit_a ? 2'b10 : (wb_hit_a ? 2'b01 : 2'b00);
  assign hz.HZ_fwd_b       = mem_hit_b ? 2'b10 : (wb_hit_b ? 2'b01 : 2'b00);
  assign hz.HZ_state       = state;
  assign hz.HZ_halted      = (state == HALTED);
  assign hz.HZ_stall_count = stall_count;
  assign hz.HZ_flush_count = flush_count;

  // Falling edge: control state (valids, FSM, counters) under reset
  always_ff @(negedge SYS_clk) begin
    if (SYS_reset) begin
      state       <= RUN;
      ex_valid    <= 1'b0;
      mem_valid   <= 1'b0;
      wb_valid    <= 1'b0;
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      ex_valid  <= !bubble;
      mem_valid <= ex_valid;
      wb_valid  <= mem_valid;
      if (load_use && !branch) stall_count <= sat_inc(stall_count);
      if (branch)              flush_count <= sat_inc(flush_count);
      case (state)
        RUN:     if (halt_go) state <= DRAIN;
        DRAIN:   if (!ex_valid && !mem_valid && !wb_valid) state <= HALTED;
        HALTED:  state <= HALTED;
        default: state <= RUN;
      endcase
    end
  end

  // Falling edge: slot payloads shift without reset; validity is tracked above
  always_ff @(negedge SYS_clk) begin
    ex_dst       <= hz.D_write_register;
    ex_regwrite  <= hz.D_RegWrite;
    ex_memread   <= hz.D_MemRead;
    ex_rs        <= hz.D_rs;
    ex_rt        <= hz.D_rt;
    ex_use_rs    <= hz.D_use_rs;
    ex_use_rt    <= hz.D_use_rt;
    mem_dst      <= ex_dst;
    mem_regwrite <= ex_regwrite;
    mem_memread  <= ex_memread;
    wb_dst       <= mem_dst;
    wb_regwrite  <= mem_regwrite;
  end

endmodule

// File: tb/tb_hazard_scheduler.sv
// Directed bench for hazard_scheduler: a default-width instance and a CNT_W=2
// instance share the same stimulus so counter saturation is visible on the second.
module tb_hazard_scheduler;

  logic       SYS_clk = 1'b0;
  logic       SYS_reset;
  logic [4:0] d_rs, d_rt, d_wr;
  logic       d_use_rs, d_use_rt, d_rw, d_mr, d_halt, ex_br;
  int         total = 0;
  int         bad   = 0;

  hazard_scheduler_if #(.CNT_W(16)) if_a ();
  hazard_scheduler_if #(.CNT_W(2))  if_s ();

  assign if_a.D_rs = d_rs;  assign if_a.D_rt = d_rt;
  assign if_a.D_use_rs = d_use_rs;  assign if_a.D_use_rt = d_use_rt;
  assign if_a.D_write_register = d_wr;  assign if_a.D_RegWrite = d_rw;
  assign if_a.D_MemRead = d_mr;  assign if_a.D_halt = d_halt;
  assign if_a.EX_branch_taken = ex_br;
  assign if_s.D_rs = d_rs;  assign if_s.D_rt = d_rt;
  assign if_s.D_use_rs = d_use_rs;  assign if_s.D_use_rt = d_use_rt;
  assign if_s.D_write_register = d_wr;  assign if_s.D_RegWrite = d_rw;
  assign if_s.D_MemRead = d_mr;  assign if_s.D_halt = d_halt;
  assign if_s.EX_branch_taken = ex_br;

  hazard_scheduler #(.CNT_W(16)) u_dut (.SYS_clk(SYS_clk), .SYS_reset(SYS_reset), .hz(if_a));
  hazard_scheduler #(.CNT_W(2))  u_sat (.SYS_clk(SYS_clk), .SYS_reset(SYS_reset), .hz(if_s));

  always #5 SYS_clk = ~SYS_clk;

  task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  task automatic dec(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                     input logic urt, input logic [4:0] wr, input logic rw,
                     input logic mr, input logic hlt, input logic br);
    d_rs = rs; d_rt = rt; d_use_rs = urs; d_use_rt = urt;
    d_wr = wr; d_rw = rw; d_mr = mr; d_halt = hlt; ex_br = br;
  endtask

  task automatic nop();
    dec(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic probe();
    @(posedge SYS_clk);
  endtask

  task automatic edge_();
    @(negedge SYS_clk);
    #1;
  endtask

  initial begin
    SYS_reset = 1'b1;
    nop();
    edge_();
    edge_();
    probe();
    chk("rst_state", if_a.HZ_state, 0);
    chk("rst_stallF", if_a.HZ_stall_F, 0);
    chk("rst_stallD", if_a.HZ_stall_D, 0);
    chk("rst_flushD", if_a.HZ_flush_D, 0);
    chk("rst_bubble", if_a.HZ_bubble_E, 0);
    chk("rst_halted", if_a.HZ_halted, 0);
    chk("rst_fwd_a", if_a.HZ_fwd_a, 0);
    chk("rst_fwd_b", if_a.HZ_fwd_b, 0);
    chk("rst_stall_cnt", if_a.HZ_stall_count, 0);
    chk("rst_flush_cnt", if_a.HZ_flush_count, 0);
    edge_();
    SYS_reset = 1'b0;

    // lw $8 then a dependent add
    dec(5'd29, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0);
    probe();
    chk("lw_no_stall", if_a.HZ_stall_F, 0);
    edge_();
    dec(5'd8, 5'd2, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
    probe();
    chk("lu_stallF", if_a.HZ_stall_F, 1);
    chk("lu_stallD", if_a.HZ_stall_D, 1);
    chk("lu_bubble", if_a.HZ_bubble_E, 1);
    chk("lu_flushD", if_a.HZ_flush_D, 0);
    edge_();
    probe();
    chk("lu_one_cycle", if_a.HZ_stall_F, 0);
    chk("lu_count", if_a.HZ_stall_count, 1);
    edge_();
    nop();
    probe();
    chk("lu_fwd_a_wb", if_a.HZ_fwd_a, 1);
    chk("lu_fwd_b_none", if_a.HZ_fwd_b, 0);
    edge_();

    // add $9; add $10,$9,$9; add $11,$9,$10
    dec(5'd1, 5'd2, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
    edge_();
    dec(5'd9, 5'd9, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0);
    probe();
    chk("alu_no_stall", if_a.HZ_stall_F, 0);
    edge_();
    dec(5'd9, 5'd10, 1'b1, 1'b1, 5'd11, 1'b1, 1'b0, 1'b0, 1'b0);
    probe();
    chk("alu2_fwd_a", if_a.HZ_fwd_a, 2);
    chk("alu2_fwd_b", if_a.HZ_fwd_b, 2);
    chk("alu2_no_stall", if_a.HZ_stall_F, 0);
    edge_();
    nop();
    probe();
    chk("alu3_fwd_a", if_a.HZ_fwd_a, 1);
    chk("alu3_fwd_b", if_a.HZ_fwd_b, 2);
    edge_();

    // load writing $0, consumer reads $0
    dec(5'd1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    edge_();
    dec(5'd0, 5'd0, 1'b1, 1'b1, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0);
    probe();
    chk("r0_no_stall", if_a.HZ_stall_F, 0);
    chk("r0_no_bubble", if_a.HZ_bubble_E, 0);
    edge_();
    nop();
    probe();
    chk("r0_fwd_a", if_a.HZ_fwd_a, 0);
    chk("r0_fwd_b", if_a.HZ_fwd_b, 0);
    edge_();

    // taken branch in the same cycle as a load-use
    dec(5'd1, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0);
    edge_();
    dec(5'd8, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1);
    probe();
    chk("br_flushD", if_a.HZ_flush_D, 1);
    chk("br_bubble", if_a.HZ_bubble_E, 1);
    chk("br_stallF", if_a.HZ_stall_F, 0);
    chk("br_stallD", if_a.HZ_stall_D, 0);
    edge_();
    nop();
    probe();
    chk("br_flush_cnt", if_a.HZ_flush_count, 1);
    chk("br_stall_cnt", if_a.HZ_stall_count, 1);
    edge_();

    // halt with older instructions still in flight
    dec(5'd1, 5'd2, 1'b1, 1'b1, 5'd13, 1'b1, 1'b0, 1'b0, 1'b0);
    edge_();
    dec(5'd1, 5'd2, 1'b1, 1'b1, 5'd14, 1'b1, 1'b0, 1'b0, 1'b0);
    edge_();
    dec(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    probe();
    chk("halt_pre_state", if_a.HZ_state, 0);
    chk("halt_pre_stallF", if_a.HZ_stall_F, 0);
    edge_();
    dec(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    probe();
    chk("n_state", if_a.HZ_state, 1);
    chk("n_stallF", if_a.HZ_stall_F, 1);
    chk("n_halted", if_a.HZ_halted, 0);
    chk("drain_br_flush", if_a.HZ_flush_D, 0);
    edge_();
    nop();
    probe();
    chk("n1_state", if_a.HZ_state, 1);
    chk("drain_flush_cnt", if_a.HZ_flush_count, 1);
    edge_();
    probe();
    chk("n2_halted", if_a.HZ_halted, 0);
    edge_();
    probe();
    chk("n3_halted", if_a.HZ_halted, 1);
    chk("n3_state", if_a.HZ_state, 2);
    chk("n3_stallF", if_a.HZ_stall_F, 1);
    chk("n3_bubble", if_a.HZ_bubble_E, 1);
    edge_();
    probe();
    chk("halted_stays", if_a.HZ_halted, 1);

    // reset out of HALTED, then five load-use stalls
    SYS_reset = 1'b1;
    edge_();
    SYS_reset = 1'b0;
    probe();
    chk("rst2_state", if_a.HZ_state, 0);
    chk("rst2_stall_cnt", if_a.HZ_stall_count, 0);
    chk("rst2_flush_cnt", if_a.HZ_flush_count, 0);
    for (int i = 0; i < 5; i++) begin
      dec(5'd29, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0);
      edge_();
      dec(5'd8, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
      probe();
      chk("sat_stall", if_s.HZ_stall_F, 1);
      edge_();
      edge_();
    end
    probe();
    chk("sat_count_16", if_a.HZ_stall_count, 5);
    chk("sat_count_2", if_s.HZ_stall_count, 3);
    chk("sat_flush_2", if_s.HZ_flush_count, 0);

    // reset during DRAIN
    dec(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    edge_();
    nop();
    probe();
    chk("drain2_state", if_s.HZ_state, 1);
    SYS_reset = 1'b1;
    edge_();
    probe();
    chk("rst3_state", if_s.HZ_state, 0);
    chk("rst3_count", if_s.HZ_stall_count, 0);
    chk("rst3_stallF", if_s.HZ_stall_F, 0);
    chk("rst3_bubble", if_s.HZ_bubble_E, 0);
    SYS_reset = 1'b0;
    edge_();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_scheduler.md
# hazard_scheduler

Pipeline interlock and sequencing controller for the five-stage core. It keeps a shadow copy of the destination-register and control information held in the EX, MEM and WB pipeline registers. From this it produces load-use stalls, branch flushes and EX-stage forwarding selects. It also sequences an orderly halt that drains the pipeline. It sits beside the decode and execution stages, and its outputs drive the PC, IF/ID and ID/EX register enables and the EX operand muxes.

## Interface
- CNT_W, 16, width of the saturating event counters
- SYS_clk  in  1  system clock; all state updates on the falling edge, matching the pipeline registers
- SYS_reset  in  1  synchronous, active-high reset
- D_rs  in  5  rs field of the instruction in decode
- D_rt  in  5  rt field of the instruction in decode
- D_use_rs  in  1  decode instruction reads rs
- D_use_rt  in  1  decode instruction reads rt
- D_write_register  in  5  destination selected in decode (rd or rt)
- D_RegWrite  in  1  decode instruction writes the register file
- D_MemRead  in  1  decode instruction is a load
- D_halt  in  1  decode instruction is a halt
- EX_branch_taken  in  1  branch in EX resolved taken this cycle
- HZ_stall_F  out  1  hold PC
- HZ_stall_D  out  1  hold IF/ID
- HZ_flush_D  out  1  load NOP into IF/ID
- HZ_bubble_E  out  1  load zero control into ID/EX
- HZ_fwd_a  out  2  EX operand1 select: 00 register, 10 MEM ALU result, 01 WB write data
- HZ_fwd_b  out  2  EX operand2 select, same encoding
- HZ_state  out  2  00 RUN, 01 DRAIN, 10 HALTED
- HZ_halted  out  1  high in HALTED
- HZ_stall_count  out  CNT_W  number of load-use stall cycles
- HZ_flush_count  out  CNT_W  number of taken-branch flushes

## Operation
- Shadow slots: EX{valid, dst, RegWrite, MemRead, rs, rt, use_rs, use_rt}, MEM{valid, dst, RegWrite, MemRead}, WB{valid, dst, RegWrite}.
- On each edge: MEM <= EX and WB <= MEM. EX <= decode fields, or an invalid bubble when HZ_bubble_E = 1.
- Match rule: slot valid, RegWrite = 1, dst != 0, and dst equals the register operand with its use bit set.
- load_use (RUN only): the EX slot is a load (MemRead = 1) and it matches D_rs or D_rt.
- On load_use: HZ_stall_F = HZ_stall_D = HZ_bubble_E = 1. HZ_stall_count increments at the edge.
- On EX_branch_taken (RUN only): HZ_flush_D = HZ_bubble_E = 1, and stall outputs are 0. The flush overrides load_use and D_halt. HZ_flush_count increments.
- Forwarding is combinational from the EX, MEM and WB slots.
  - fwd_a = 10 if the MEM slot matches EX.rs and MEM.MemRead = 0.
  - Otherwise fwd_a = 01 if the WB slot matches EX.rs.
  - Otherwise fwd_a = 00.
  - fwd_b uses EX.rt in the same way.
  - MEM has priority over WB. Register 0 never forwards.
- FSM:
  - RUN -> DRAIN at the edge where D_halt = 1, load_use = 0 and EX_branch_taken = 0. The halt itself enters EX as a bubble.
  - DRAIN: HZ_stall_F = HZ_stall_D = HZ_bubble_E = 1, and EX_branch_taken is ignored. DRAIN -> HALTED at the edge where all three slots are invalid.
  - HALTED: same hold outputs as DRAIN, HZ_halted = 1. Leaves HALTED only on reset.
- Counters saturate at all-ones and do not wrap.

## Timing
- Reset (at an SYS_clk falling edge with SYS_reset = 1):
  - All slots invalid; state RUN; both counters 0.
  - HZ_fwd_a = HZ_fwd_b = 00.
  - HZ_stall_F, HZ_stall_D, HZ_flush_D, HZ_bubble_E and HZ_halted are all 0.
- Reset asserted mid-drain or mid-stall returns to RUN at that edge with all slots cleared.
- All outputs are combinational from the current slots, state and D inputs; they are valid in the same cycle. State changes at the falling edge.
- A load-use stall lasts exactly 1 cycle. After it, the load sits in the WB slot when the consumer reaches EX, so fwd = 01.
- A taken branch flushes for 1 cycle, removing 2 wrong-path instructions (IF/ID and ID/EX).
- Halt accepted at edge n: HZ_state = DRAIN after edge n, and HZ_halted = 1 after edge n+3 (the latest that older instructions can retire).

## Test plan
- Load then dependent add:
  - Stimulus: `lw $8` in EX; decode has D_rs = 8, D_use_rs = 1.
  - Response: stall/bubble = 1 for one cycle; stall_count = 1. Next cycle, with the add in EX, fwd_a = 01.
- Back-to-back ALU dependencies:
  - Stimulus: `add $9`, `add $10,$9,$9`, `add $11,$9,$10`.
  - Response: for the second add, fwd_a = fwd_b = 10. For the third add, fwd_a = 01 and fwd_b = 10. No stall.
- Register 0:
  - Stimulus: a load writing $0 in EX; decode reads $0.
  - Response: no stall; fwd = 00.
- Branch taken with load-use pending in the same cycle:
  - Response: flush_D = bubble_E = 1 and stall_F = 0; flush_count = 1 and stall_count unchanged.
- Halt:
  - Stimulus: halt in decode at edge n, with 2 valid instructions ahead of it.
  - Response: state 01 after edge n; halted = 1 after edge n+3. stall_F stays 1. An EX_branch_taken pulse during DRAIN changes nothing.
- Counter saturation with CNT_W = 2:
  - Stimulus: 5 load-use stalls.
  - Response: stall_count = 3. A reset during DRAIN returns to state 00 with counts 0.
